// File: rtl/memblk_pkg.sv
// Shared constants for the memblk port scheduler: bus widths and the fixed
// read latency of the memblk macro.
package memblk_pkg;

  localparam int unsigned ADDR_W     = 39;
  localparam int unsigned DATA_W     = 8 * 66 + 5;
  localparam int unsigned MEMBLK_LAT = 48;
  localparam int unsigned OUT_W      = 7;

endpackage

// File: rtl/memblk_port_sched_if.sv
// Requester and memblk signal bundle seen by one port scheduler instance.
// The master modport is the environment side; the slave modport is the scheduler.
interface memblk_port_sched_if
  import memblk_pkg::*;
#(
  parameter int unsigned NREQ = 8
);

  logic                               stall;
  logic [NREQ-1:0]                    req_valid;
  logic [NREQ-1:0]                    req_we;
  logic [NREQ-1:0][ADDR_W-1:0]        req_addr;
  logic [NREQ-1:0][DATA_W-1:0]        req_wdata;
  logic [NREQ-1:0]                    req_ready;
  logic [ADDR_W-1:0]                  mem_rdaddr0;
  logic                               mem_rden;
  logic [ADDR_W-1:0]                  mem_wraddr0;
  logic [DATA_W-1:0]                  mem_wrdata;
  logic                               mem_wren;
  logic                               mem_rden_out;
  logic [DATA_W-1:0]                  mem_rddata;
  logic [NREQ-1:0]                    resp_valid;
  logic [DATA_W-1:0]                  resp_data;
  logic [OUT_W-1:0]                   outstanding;
  logic                               tag_err;

  modport master (
    output stall, req_valid, req_we, req_addr, req_wdata, mem_rden_out, mem_rddata,
    input  req_ready, mem_rdaddr0, mem_rden, mem_wraddr0, mem_wrdata, mem_wren,
    input  resp_valid, resp_data, outstanding, tag_err
  );

  modport slave (
    input  stall, req_valid, req_we, req_addr, req_wdata, mem_rden_out, mem_rddata,
    output req_ready, mem_rdaddr0, mem_rden, mem_wraddr0, mem_wrdata, mem_wren,
    output resp_valid, resp_data, outstanding, tag_err
  );

endinterface

// File: rtl/memblk_port_sched_rr_arb.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping; the pointer moves past the winner only when adv_i is high.
module rr_arb #(
  parameter  int unsigned N    = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            adv_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  logic            found;
  int unsigned     k;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_q) + i) % N;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx      = IdxW'(k);
      end
    end
  end

  assign gnt_idx_o = idx;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/memblk_port_sched.sv
// Shares one memblk read and one write port among NREQ requesters; an in-order
// tag FIFO routes each read return back to the requester that issued it.
module memblk_port_sched
  import memblk_pkg::*;
#(
  parameter int unsigned NREQ       = 8,
  parameter int unsigned MAX_OUT    = 48,
  parameter int unsigned TAGQ_DEPTH = 64
) (
  input logic                clk,
  input logic                rst,
  memblk_port_sched_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned PtrW = $clog2(TAGQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdxW-1:0] req_idx_t;

  logic [NREQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  req_idx_t        rd_idx, wr_idx;
  logic            rd_issue, wr_issue;
  logic            arb_en, credit_ok, ret_acc, pop;

  req_idx_t              tagq_q [TAGQ_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  tag_err_q, tag_err_d;

  // Returns are only accepted when unstalled; with nothing tracked they are flagged, not popped.
  assign ret_acc   = bus.mem_rden_out && !bus.stall;
  assign pop       = ret_acc && (cnt_q != '0);
  assign credit_ok = (cnt_q < CntW'(MAX_OUT)) || ((cnt_q == CntW'(MAX_OUT)) && pop);
  assign arb_en    = rst && !bus.stall;

  assign rd_req = bus.req_valid & ~bus.req_we & {NREQ{arb_en && credit_ok}};
  assign wr_req = bus.req_valid &  bus.req_we & {NREQ{arb_en}};

  rr_arb #(.N(NREQ)) u_rd_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (rd_req),
    .adv_i     (rd_issue),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx)
  );

  rr_arb #(.N(NREQ)) u_wr_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (wr_req),
    .adv_i     (wr_issue),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx)
  );

  assign rd_issue = |rd_gnt;
  assign wr_issue = |wr_gnt;

  assign bus.req_ready   = rd_gnt | wr_gnt;
  assign bus.mem_rden    = rd_issue;
  assign bus.mem_rdaddr0 = rd_issue ? bus.req_addr[rd_idx] : '0;
  assign bus.mem_wren    = wr_issue;
  assign bus.mem_wraddr0 = wr_issue ? bus.req_addr[wr_idx] : '0;
  assign bus.mem_wrdata  = wr_issue ? bus.req_wdata[wr_idx] : '0;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.outstanding = OUT_W'(cnt_q);
  assign bus.tag_err     = tag_err_q;

  always_comb begin
    wr_ptr_d     = rd_issue ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d        = cnt_q;
    unique case ({rd_issue, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (pop) begin
      resp_valid_d[tagq_q[rd_ptr_q]] = 1'b1;
      resp_data_d                    = bus.mem_rddata;
    end
    tag_err_d    = tag_err_q | (ret_acc && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rd_issue) begin
      tagq_q[wr_ptr_q] <= rd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      tag_err_q    <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_memblk_port_sched.sv
// Directed bench for memblk_port_sched with MAX_OUT=4; memblk returns are
// driven by hand and every expected value is worked out in the steps below.
module tb_memblk_port_sched;
  import memblk_pkg::*;

  localparam int unsigned NREQ = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  memblk_port_sched_if #(.NREQ(NREQ)) bus ();

  memblk_port_sched #(
    .NREQ       (NREQ),
    .MAX_OUT    (4),
    .TAGQ_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int unsigned n);
    logic [543:0] t;
    t = {17{32'h0101_0101 * n + 32'h0000_1234}};
    return t[DATA_W-1:0];
  endfunction

  initial begin
    rst              = 1'b0;
    bus.stall        = 1'b0;
    bus.req_valid    = '0;
    bus.req_we       = '0;
    bus.mem_rden_out = 1'b0;
    bus.mem_rddata   = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i]  = ADDR_W'(32'h100 + i);
      bus.req_wdata[i] = mk_data(100 + i);
    end

    // Reset: outputs quiet even with requests present
    bus.req_valid = 8'h0F;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rden", bus.mem_rden, 0);
    tick();
    tick();
    chk("rst_out", bus.outstanding, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_tag_err", bus.tag_err, 0);
    chk("rst_ready2", bus.req_ready, 0);

    // Four reads, granted 0,1,2,3 one per cycle
    rst = 1'b1;
    #1;
    chk("rd0_ready", bus.req_ready, 8'h01);
    chk("rd0_addr", bus.mem_rdaddr0, 39'h100);
    chk("rd0_rden", bus.mem_rden, 1);
    chk("rd0_wren", bus.mem_wren, 0);
    chk("rd0_wraddr", bus.mem_wraddr0, 0);
    tick();
    chk("rd1_ready", bus.req_ready, 8'h02);
    chk("rd1_addr", bus.mem_rdaddr0, 39'h101);
    chk("rd1_out", bus.outstanding, 1);
    tick();
    chk("rd2_ready", bus.req_ready, 8'h04);
    chk("rd2_out", bus.outstanding, 2);
    tick();
    chk("rd3_ready", bus.req_ready, 8'h08);
    chk("rd3_out", bus.outstanding, 3);
    tick();
    chk("full_ready", bus.req_ready, 0);
    chk("full_rden", bus.mem_rden, 0);
    chk("full_out", bus.outstanding, 4);

    // Return while full: pop and grant the same cycle (pointer 4 wraps to 0)
    bus.mem_rden_out = 1'b1;
    bus.mem_rddata   = mk_data(0);
    #1;
    chk("full_ret_ready", bus.req_ready, 8'h01);
    tick();
    chk("full_ret_out", bus.outstanding, 4);
    chk("resp0_valid", bus.resp_valid, 8'h01);
    chk("resp0_data", bus.resp_data, mk_data(0));

    bus.req_valid  = '0;
    bus.mem_rddata = mk_data(1);
    tick();
    chk("resp1_valid", bus.resp_valid, 8'h02);
    chk("resp1_data", bus.resp_data, mk_data(1));
    chk("resp1_out", bus.outstanding, 3);
    bus.mem_rddata = mk_data(2);
    tick();
    chk("resp2_valid", bus.resp_valid, 8'h04);
    chk("resp2_data", bus.resp_data, mk_data(2));
    bus.mem_rddata = mk_data(3);
    tick();
    chk("resp3_valid", bus.resp_valid, 8'h08);
    chk("resp3_data", bus.resp_data, mk_data(3));
    bus.mem_rddata = mk_data(4);
    tick();
    chk("resp4_valid", bus.resp_valid, 8'h01);
    chk("resp4_data", bus.resp_data, mk_data(4));
    chk("resp4_out", bus.outstanding, 0);
    bus.mem_rden_out = 1'b0;
    tick();
    chk("idle_resp_valid", bus.resp_valid, 0);
    chk("idle_resp_hold", bus.resp_data, mk_data(4));
    chk("idle_tag_err", bus.tag_err, 0);

    // Simultaneous read (req 2) and write (req 5)
    bus.req_addr[2]  = 39'h10;
    bus.req_addr[5]  = 39'h55;
    bus.req_valid    = 8'h24;
    bus.req_we       = 8'h20;
    #1;
    chk("rw_ready", bus.req_ready, 8'h24);
    chk("rw_rden", bus.mem_rden, 1);
    chk("rw_wren", bus.mem_wren, 1);
    chk("rw_rdaddr", bus.mem_rdaddr0, 39'h10);
    chk("rw_wraddr", bus.mem_wraddr0, 39'h55);
    chk("rw_wrdata", bus.mem_wrdata, mk_data(105));
    tick();
    chk("rw_out", bus.outstanding, 1);

    // Stall with reads 0,1 and writes 4,6 pending; stray return must be ignored
    bus.req_valid    = 8'h53;
    bus.req_we       = 8'h50;
    bus.stall        = 1'b1;
    bus.mem_rden_out = 1'b1;
    bus.mem_rddata   = mk_data(7);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_rden", bus.mem_rden, 0);
      chk("stall_wren", bus.mem_wren, 0);
      tick();
      chk("stall_out", bus.outstanding, 1);
      chk("stall_resp", bus.resp_valid, 0);
    end
    chk("stall_tag_err", bus.tag_err, 0);
    bus.stall        = 1'b0;
    bus.mem_rden_out = 1'b0;
    #1;
    chk("unstall_ready", bus.req_ready, 8'h41);
    chk("unstall_rdaddr", bus.mem_rdaddr0, 39'h100);
    chk("unstall_wraddr", bus.mem_wraddr0, 39'h106);
    tick();
    chk("unstall_out", bus.outstanding, 2);

    // Third read in flight, then reset mid-operation
    bus.req_valid = 8'h02;
    bus.req_we    = '0;
    #1;
    chk("pre_rst_ready", bus.req_ready, 8'h02);
    tick();
    chk("pre_rst_out", bus.outstanding, 3);
    rst           = 1'b0;
    bus.req_valid = 8'h0F;
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    tick();
    chk("mid_rst_out", bus.outstanding, 0);
    chk("mid_rst_resp", bus.resp_valid, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", bus.req_ready, 8'h01);
    tick();
    chk("post_rst_out", bus.outstanding, 1);
    bus.req_valid    = '0;
    bus.mem_rden_out = 1'b1;
    bus.mem_rddata   = mk_data(5);
    tick();
    chk("post_rst_resp", bus.resp_valid, 8'h01);
    chk("post_rst_data", bus.resp_data, mk_data(5));
    chk("post_rst_out0", bus.outstanding, 0);
    chk("post_rst_tag_err", bus.tag_err, 0);

    // Return with nothing in flight sets sticky tag_err
    bus.mem_rddata = mk_data(6);
    tick();
    chk("terr_set", bus.tag_err, 1);
    chk("terr_resp", bus.resp_valid, 0);
    chk("terr_data_hold", bus.resp_data, mk_data(5));
    chk("terr_out", bus.outstanding, 0);
    bus.mem_rden_out = 1'b0;
    tick();
    chk("terr_sticky", bus.tag_err, 1);
    chk("terr_resp2", bus.resp_valid, 0);
    rst = 1'b0;
    tick();
    chk("terr_clear", bus.tag_err, 0);
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memblk_port_sched.md
Name: memblk_port_sched

Overview:
- Shares one memblk read port and one memblk write port between NREQ requesters.
- Two independent round-robin arbiters per cycle: one grant among read requesters, one among write requesters.
- Honours memblk `stall`. Tracks outstanding reads in a tag FIFO so each `rden_out` return is routed to the requester that issued it.
- Instantiated once per memblk port index in the tile.

Parameters:
- NREQ, 8, number of requesters (2..16).
- MAX_OUT, 48, maximum reads in flight; must be ≤ TAGQ_DEPTH.
- TAGQ_DEPTH, 64, tag FIFO entries (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- stall  in  1  memblk stall; pipeline frozen while 1
- req_valid  in  [NREQ]  request present
- req_we  in  [NREQ]  1=write, 0=read
- req_addr  in  [NREQ][38:0]  address, memblk rdaddr0/wraddr0 format
- req_wdata  in  [NREQ][8*66+4:0]  write data
- req_ready  out  [NREQ]  request accepted this cycle (combinational grant)
- mem_rdaddr0  out  [38:0]  to memblk rdaddr0
- mem_rden  out  1  to memblk rden_in
- mem_wraddr0  out  [38:0]  to memblk wraddr0
- mem_wrdata  out  [8*66+4:0]  to memblk wrdata
- mem_wren  out  1  to memblk wren_in
- mem_rden_out  in  1  from memblk rden_out
- mem_rddata  in  [8*66+4:0]  from memblk rddata
- resp_valid  out  [NREQ]  one-hot read response
- resp_data  out  [8*66+4:0]  read data, shared by all requesters
- outstanding  out  [6:0]  reads in flight
- tag_err  out  1  sticky: return arrived with tag FIFO empty

Behaviour:
- Reset (rst==0 at posedge):
  - both RR pointers = 0, tag FIFO empty, outstanding = 0, resp_valid = 0, resp_data = 0, tag_err = 0.
  - mem_rden, mem_wren and req_ready are 0 while rst==0.
- Eligibility:
  - read candidates = req_valid & ~req_we; write candidates = req_valid & req_we.
  - each requester has one request, so it is never in both sets.
- Arbitration:
  - each arbiter picks the first candidate at or above its pointer, wrapping modulo NREQ.
  - after a grant, that pointer := granted index + 1 (mod NREQ); with no grant the pointer holds.
- Issue (combinational, same cycle as grant):
  - mem_rden = read grant; mem_rdaddr0 = granted req_addr.
  - mem_wren = write grant; mem_wraddr0 / mem_wrdata from the write winner.
  - req_ready = read grant | write grant (at most 2 bits set).
  - unselected mem address/data outputs are 0.
- Stall: when stall==1, no grants, mem_rden = mem_wren = 0, pointers frozen, mem_rden_out ignored.
- Read credit: a read is granted only if outstanding < MAX_OUT, or outstanding == MAX_OUT and a return is accepted the same cycle.
- Tag FIFO:
  - push the granted read's requester index on a read issue.
  - pop on an accepted return (mem_rden_out && !stall).
  - push and pop in the same cycle are both performed, occupancy unchanged.
  - outstanding = occupancy; it never exceeds MAX_OUT.
- Response path, registered with 1-cycle latency: the cycle after an accepted return, resp_valid[popped index] = 1 and resp_data = mem_rddata captured at acceptance. Otherwise resp_valid = 0 and resp_data holds.
- Empty FIFO: a return with the FIFO empty sets tag_err (stays set until reset), nothing is popped, no resp_valid. Ordering is in-order only, matching the fixed memblk latency.
- Reset mid-operation: in-flight reads are dropped. Any memblk returns after reset with the FIFO empty set tag_err; the integration asserts reset on both blocks together so this does not occur.

Decomposition:
- Shared package memblk_pkg:
  - ADDR_W=39, DATA_W=8*66+5, MEMBLK_LAT=48 constants
  - typedef req_idx_t = logic[$clog2(NREQ)-1:0], defined locally because it is parameter-dependent
- Sub-module rr_arb, instantiated twice (read, write). Parameter N; inputs req[N], adv; outputs gnt[N] one-hot, gnt_idx. Pointer internal, advanced when adv.
- Tag FIFO is inline.

Test Plan:
- Reset, then req_valid=0x0F, req_we=0: grants in order 0,1,2,3, one per cycle, each to the lowest eligible index at or above the pointer. After read-latency cycles, resp_valid one-hot 0x01, 0x02, 0x04, 0x08 in that order with the matching data.
- Requester 2 read (addr 0x10) and requester 5 write in the same cycle: req_ready=0x24, mem_rden=1, mem_wren=1, outstanding 0→1.
- Stall held 3 cycles with requests pending: req_ready=0, mem_rden=mem_wren=0, pointers unchanged. The first grant after stall drops goes to the same index that would have been granted before the stall.
- MAX_OUT=4, continuous reads, no returns: exactly 4 grants, then req_ready=0 with outstanding=4. A return with a pending read: pop and grant in the same cycle, outstanding stays 4.
- mem_rden_out pulsed with no reads issued: tag_err=1 and stays 1, resp_valid stays 0. After rst=0 for 1 cycle: tag_err=0.
- rst=0 asserted with 3 reads in flight: outstanding=0 and resp_valid=0 the next cycle; the pointer restarts so requester 0 is granted first.
